vfpu_core: RTL and testbench

Single-precision (IEEE-754 binary32) floating-point add/subtract unit serving as the arithmetic engine of the HWPE vector-FPU accelerator. It accepts one operand pair per clock with a valid qualifier and returns a rounded result plus exception flags through a fixed-latency, non-stalling 3-stage pipeline. Operation, operand and flag types come from `hwpe_ctrl_vfpu_package`.

---
 rtl/vfpu_core.sv | 248 ++++++++++++++++++++++++
 tb/tb_vfpu_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vfpu_core.sv
// Single-precision (binary32) add/subtract engine for the HWPE vector FPU.
// Three-stage, fixed-latency, non-stalling pipeline; denormals flush to zero.
package hwpe_ctrl_vfpu_package;
   typedef struct packed {
      logic        sign;
      logic [7:0]  exponent;
      logic [22:0] mantissa;
   } fp_t;

   typedef struct packed {
      logic [1:0] operation;
      logic [1:0] rounding_mode;
   } ctrl_vfpu_t;

   typedef struct packed {
      logic invalid;
      logic overflow;
      logic underflow;
      logic inexact;
      logic zero;
   } flags_vfpu_t;

   localparam logic [1:0] FP_OP_SUB       = 2'd1;
   localparam logic [1:0] FP_RM_NEAREST   = 2'd0;
   localparam logic [1:0] FP_RM_ZERO      = 2'd1;
   localparam logic [1:0] FP_RM_PLUS_INF  = 2'd2;
   localparam logic [1:0] FP_RM_MINUS_INF = 2'd3;
endpackage

module vfpu_core
   import hwpe_ctrl_vfpu_package::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] operandA_i,
   input  logic [31:0] operandB_i,
   input  logic [3:0]  ctrl_vfpu_i,
   input  logic        operands_valid_i,
   output logic [31:0] result_o,
   output logic [4:0]  flags_vfpu_o,
   output logic        ready_o,
   output logic        done_o
);

   // Handshake: a beat is accepted on every rising edge where operands_valid_i=1
   // and ready_o=1; ready_o never drops outside reset, and each accepted beat
   // produces exactly one done_o pulse two edges later, in order.
   assign ready_o = ~rst_i;

   // ---------------- S1: unpack, specials, swap, align ----------------
   fp_t        a, b, u_spec_res;
   ctrl_vfpu_t ctrl;
   logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic       swap, eff_sub, sign_x, zero_sign, u_invalid, u_special;
   logic [23:0] sig_a, sig_b, sig_x, sig_y;
   logic [7:0]  exp_x, exp_y, exp_d;
   logic [49:0] y_wide;
   logic [26:0] x_al, y_al;

   assign ctrl = ctrl_vfpu_i;
   assign a    = operandA_i;
   assign b    = {operandB_i[31] ^ (ctrl.operation == FP_OP_SUB), operandB_i[30:0]};

   always_comb begin
      a_nan     = (&a.exponent) & (|a.mantissa);
      b_nan     = (&b.exponent) & (|b.mantissa);
      a_inf     = (&a.exponent) & ~(|a.mantissa);
      b_inf     = (&b.exponent) & ~(|b.mantissa);
      a_zero    = (a.exponent == 8'd0);
      b_zero    = (b.exponent == 8'd0);
      sig_a     = a_zero ? 24'd0 : {1'b1, a.mantissa};
      sig_b     = b_zero ? 24'd0 : {1'b1, b.mantissa};
      eff_sub   = a.sign ^ b.sign;
      u_invalid = a_nan | b_nan | (a_inf & b_inf & eff_sub);
      u_special = u_invalid | a_inf | b_inf;
      u_spec_res = u_invalid ? fp_t'(32'h7FC0_0000) : (a_inf ? a : b);
      swap      = {b.exponent, sig_b} > {a.exponent, sig_a};
      sign_x    = swap ? b.sign : a.sign;
      exp_x     = swap ? b.exponent : a.exponent;
      exp_y     = swap ? a.exponent : b.exponent;
      sig_x     = swap ? sig_b : sig_a;
      sig_y     = swap ? sig_a : sig_b;
      exp_d     = exp_x - exp_y;
      y_wide    = {sig_y, 26'd0} >> exp_d;
      x_al      = {sig_x, 3'b000};
      // Past 26 positions the smaller operand only survives as sticky.
      y_al      = (exp_d >= 8'd26) ? {26'd0, |sig_y} : {y_wide[49:24], |y_wide[23:0]};
      zero_sign = eff_sub ? (ctrl.rounding_mode == FP_RM_MINUS_INF) : sign_x;
   end

   logic        s1_valid, s1_special, s1_invalid, s1_sub, s1_sign, s1_zsign;
   logic [31:0] s1_spec_res;
   logic [7:0]  s1_exp;
   logic [26:0] s1_x, s1_y;
   logic [1:0]  s1_rm;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid    <= 1'b0;
         s1_special  <= 1'b0;
         s1_invalid  <= 1'b0;
         s1_sub      <= 1'b0;
         s1_sign     <= 1'b0;
         s1_zsign    <= 1'b0;
         s1_spec_res <= 32'd0;
         s1_exp      <= 8'd0;
         s1_x        <= 27'd0;
         s1_y        <= 27'd0;
         s1_rm       <= 2'd0;
      end else begin
         s1_valid <= operands_valid_i;
         if (operands_valid_i) begin
            s1_special  <= u_special;
            s1_invalid  <= u_invalid;
            s1_sub      <= eff_sub;
            s1_sign     <= sign_x;
            s1_zsign    <= zero_sign;
            s1_spec_res <= u_spec_res;
            s1_exp      <= exp_x;
            s1_x        <= x_al;
            s1_y        <= y_al;
            s1_rm       <= ctrl.rounding_mode;
         end
      end
   end

   // ---------------- S2: add/subtract, normalise ----------------
   logic [27:0] sum;
   logic [4:0]  lz;
   logic [26:0] norm;
   logic [9:0]  norm_exp;

   always_comb begin
      sum = s1_sub ? ({1'b0, s1_x} - {1'b0, s1_y}) : ({1'b0, s1_x} + {1'b0, s1_y});
      lz  = 5'd0;
      for (int i = 0; i < 27; i++) begin
         if (sum[i]) lz = 5'(26 - i);
      end
      if (sum[27]) begin
         norm     = {sum[27:2], sum[1] | sum[0]};
         norm_exp = {2'b00, s1_exp} + 10'd1;
      end else begin
         norm     = sum[26:0] << lz;
         norm_exp = {2'b00, s1_exp} - {5'd0, lz};
      end
   end

   logic        s2_valid, s2_special, s2_invalid, s2_sign, s2_zsign, s2_zero;
   logic [31:0] s2_spec_res;
   logic [9:0]  s2_exp;
   logic [26:0] s2_norm;
   logic [1:0]  s2_rm;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s2_valid    <= 1'b0;
         s2_special  <= 1'b0;
         s2_invalid  <= 1'b0;
         s2_sign     <= 1'b0;
         s2_zsign    <= 1'b0;
         s2_zero     <= 1'b0;
         s2_spec_res <= 32'd0;
         s2_exp      <= 10'd0;
         s2_norm     <= 27'd0;
         s2_rm       <= 2'd0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_special  <= s1_special;
            s2_invalid  <= s1_invalid;
            s2_sign     <= s1_sign;
            s2_zsign    <= s1_zsign;
            s2_zero     <= (sum == 28'd0);
            s2_spec_res <= s1_spec_res;
            s2_exp      <= norm_exp;
            s2_norm     <= norm;
            s2_rm       <= s1_rm;
         end
      end
   end

   // ---------------- S3: round, pack ----------------
   logic [23:0] mant;
   logic        guard, round_bit, sticky, inexact, round_up, under, over;
   logic [24:0] rounded;
   logic [9:0]  exp_r;
   logic [22:0] mant_r;
   fp_t         res_n, max_fin, inf_val;
   flags_vfpu_t flg_n;

   always_comb begin
      {mant, guard, round_bit, sticky} = s2_norm;
      inexact = guard | round_bit | sticky;
      case (s2_rm)
         FP_RM_NEAREST:  round_up = guard & (round_bit | sticky | mant[0]);
         FP_RM_ZERO:     round_up = 1'b0;
         FP_RM_PLUS_INF: round_up = inexact & ~s2_sign;
         default:        round_up = inexact & s2_sign;
      endcase
      rounded = {1'b0, mant} + {24'd0, round_up};
      exp_r   = s2_exp + {9'd0, rounded[24]};
      mant_r  = rounded[24] ? rounded[23:1] : rounded[22:0];
      // Exponent is two's complement here; bit 9 marks a negative value.
      under   = s2_exp[9] | (s2_exp == 10'd0);
      over    = (exp_r >= 10'd255);
      max_fin = {s2_sign, 8'hFE, 23'h7F_FFFF};
      inf_val = {s2_sign, 8'hFF, 23'd0};
      flg_n   = '0;
      res_n   = {s2_sign, exp_r[7:0], mant_r};
      if (s2_special) begin
         res_n         = s2_spec_res;
         flg_n.invalid = s2_invalid;
      end else if (s2_zero) begin
         res_n      = {s2_zsign, 31'd0};
         flg_n.zero = 1'b1;
      end else if (under) begin
         res_n           = {s2_sign, 31'd0};
         flg_n.underflow = 1'b1;
         flg_n.inexact   = 1'b1;
      end else if (over) begin
         flg_n.overflow = 1'b1;
         flg_n.inexact  = 1'b1;
         case (s2_rm)
            FP_RM_NEAREST:  res_n = inf_val;
            FP_RM_ZERO:     res_n = max_fin;
            FP_RM_PLUS_INF: res_n = s2_sign ? max_fin : inf_val;
            default:        res_n = s2_sign ? inf_val : max_fin;
         endcase
      end else begin
         flg_n.inexact = inexact;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         done_o       <= 1'b0;
         result_o     <= 32'd0;
         flags_vfpu_o <= 5'd0;
      end else begin
         done_o <= s2_valid;
         if (s2_valid) begin
            result_o     <= res_n;
            flags_vfpu_o <= flg_n;
         end
      end
   end

endmodule

// File: tb/tb_vfpu_core.sv
// Bench for vfpu_core: exact-arithmetic reference model, per-cycle compare of
// done/result/flags against a due-cycle scoreboard, plus literal vectors.
module tb_vfpu_core;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] operand_a, operand_b;
   logic [3:0]  ctrl;
   logic        valid;
   logic [31:0] result;
   logic [4:0]  flags;
   logic        ready, done;

   vfpu_core dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .operandA_i       (operand_a),
      .operandB_i       (operand_b),
      .ctrl_vfpu_i      (ctrl),
      .operands_valid_i (valid),
      .result_o         (result),
      .flags_vfpu_o     (flags),
      .ready_o          (ready),
      .done_o           (done)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          failures = 0;
   logic [36:0] exp_q[$];
   int          due_q[$];
   logic [36:0] last_exp = '0;

   task automatic check(input string name, input logic [38:0] act, input logic [38:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got=%h expected=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Operands are turned into exact integers scaled by 2^149, summed exactly,
   // then rounded to 24 significant bits by the chosen mode.
   function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b_in,
                                         input logic [3:0] c);
      logic [31:0]  b;
      logic [1:0]   rm;
      logic         sa, sb, za, zb, sign, inexact, up;
      logic [319:0] va, vb, mag, mant, rem, half;
      int           p, e, sh;
      rm = c[1:0];
      b  = b_in;
      if (c[3:2] == 2'd1) b[31] = ~b[31];
      sa = a[31];
      sb = b[31];
      if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0) ||
          (a[30:23] == 8'hFF && b[30:23] == 8'hFF && sa != sb))
         return {32'h7FC0_0000, 5'b10000};
      if (a[30:23] == 8'hFF) return {a, 5'b00000};
      if (b[30:23] == 8'hFF) return {b, 5'b00000};
      za = (a[30:23] == 8'd0);
      zb = (b[30:23] == 8'd0);
      if (za && zb) return {((sa == sb) ? sa : (rm == 2'd3)), 31'd0, 5'b00001};
      va = za ? 320'd0 : (320'({1'b1, a[22:0]}) << (int'(a[30:23]) - 1));
      vb = zb ? 320'd0 : (320'({1'b1, b[22:0]}) << (int'(b[30:23]) - 1));
      if (sa == sb) begin
         mag = va + vb; sign = sa;
      end else if (va >= vb) begin
         mag = va - vb; sign = sa;
      end else begin
         mag = vb - va; sign = sb;
      end
      if (mag == 0) return {(rm == 2'd3), 31'd0, 5'b00001};
      p = 0;
      for (int i = 0; i < 320; i++) if (mag[i]) p = i;
      e = p - 22;
      if (e <= 0) return {sign, 31'd0, 5'b00110};
      sh      = p - 23;
      mant    = mag >> sh;
      rem     = mag - (mant << sh);
      half    = (sh > 0) ? (320'd1 << (sh - 1)) : 320'd0;
      inexact = (rem != 0);
      case (rm)
         2'd0:    up = inexact && ((rem > half) || (rem == half && mant[0]));
         2'd1:    up = 1'b0;
         2'd2:    up = inexact && !sign;
         default: up = inexact && sign;
      endcase
      mant = mant + 320'(up);
      if (mant[24]) begin
         mant = mant >> 1;
         e++;
      end
      if (e >= 255) begin
         if (rm == 2'd0 || (rm == 2'd2 && !sign) || (rm == 2'd3 && sign))
            return {sign, 8'hFF, 23'd0, 5'b01010};
         return {sign, 8'hFE, 23'h7F_FFFF, 5'b01010};
      end
      return {sign, 8'(e), mant[22:0], 3'b000, inexact, 1'b0};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                       input logic [36:0] expv);
      operand_a = a;
      operand_b = b;
      ctrl      = c;
      valid     = 1'b1;
      exp_q.push_back(expv);
      due_q.push_back(cyc + 3);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      repeat (n) begin
         operand_a = $urandom;
         operand_b = $urandom;
         ctrl      = 4'($urandom_range(0, 15));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c, input logic [31:0] r, input logic [4:0] f);
      check({"model_", name}, {2'b00, model(a, b, c)}, {2'b00, r, f});
      send(a, b, c, {r, f});
   endtask

   function automatic logic [31:0] rand_fp(input int base);
      logic [31:0] v;
      int          e;
      v = $urandom;
      case ($urandom_range(0, 19))
         0: v[30:0] = 31'd0;
         1: v[30:23] = 8'd0;
         2: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
         3: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
         4: v[30:23] = 8'(254 - $urandom_range(0, 1));
         5: v[30:23] = 8'($urandom_range(1, 3));
         default: begin
            e = base + int'($urandom_range(0, 60)) - 30;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
            v[30:23] = 8'(e);
         end
      endcase
      return v;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (ready !== 1'b1) begin
            failures++;
            $display("FAIL ready got=%b expected=1 (t=%0t)", ready, $time);
         end
         if (due_q.size() > 0 && due_q[0] < cyc) begin
            checks++;
            failures++;
            $display("FAIL lost_result got=none expected=%h (t=%0t)", exp_q[0], $time);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
         end
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            last_exp = exp_q.pop_front();
            void'(due_q.pop_front());
            check("pipe_out", {1'b0, done, result, flags}, {2'b01, last_exp});
         end else begin
            check("idle_hold", {1'b0, done, result, flags}, {2'b00, last_exp});
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] a, b;
      valid     = 1'b0;
      operand_a = '0;
      operand_b = '0;
      ctrl      = '0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {result, flags, done, ready}, 39'd0);
      rst = 1'b0;
      #1;
      check("ready_after_reset", {38'd0, ready}, 39'd1);
      idle(3);

      // back-to-back SUB, round to nearest
      directed("sub1", 32'h41A40000, 32'h408A3D71, 4'b0100, 32'h418170A4, 5'b00010);
      directed("sub2", 32'h4818E200, 32'h40200000, 4'b0100, 32'h4818E160, 5'b00000);
      directed("sub3", 32'h40B80000, 32'h4311CCCD, 4'b0100, 32'hC30C0CCD, 5'b00000);
      directed("sub4", 32'h3ACC78EA, 32'h44D2F4CD, 4'b0100, 32'hC4D2F4C0, 5'b00010);
      idle(4);

      directed("cancel_rne", 32'h40490FDB, 32'h40490FDB, 4'b0100, 32'h00000000, 5'b00001);
      directed("cancel_rmi", 32'h40490FDB, 32'h40490FDB, 4'b0111, 32'h80000000, 5'b00001);
      directed("ovf_rne",    32'h7F7FFFFF, 32'h7F7FFFFF, 4'b0000, 32'h7F800000, 5'b01010);
      directed("ovf_rz",     32'h7F7FFFFF, 32'h7F7FFFFF, 4'b0001, 32'h7F7FFFFF, 5'b01010);
      directed("inf_m_inf",  32'h7F800000, 32'h7F800000, 4'b0100, 32'h7FC00000, 5'b10000);
      directed("underflow",  32'h00800001, 32'h00800000, 4'b0100, 32'h00000000, 5'b00110);
      directed("underflow_n", 32'h00800000, 32'h00800001, 4'b0100, 32'h80000000, 5'b00110);
      directed("inf_p_fin",  32'h7F800000, 32'h3F800000, 4'b0000, 32'h7F800000, 5'b00000);
      directed("nzero_sum",  32'h80000000, 32'h80000000, 4'b0000, 32'h80000000, 5'b00001);
      directed("rsvd_op_add", 32'h3F800000, 32'h3F800000, 4'b1000, 32'h40000000, 5'b00000);
      idle(4);

      // randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         a = rand_fp(int'($urandom_range(1, 254)));
         if ($urandom_range(0, 3) == 0) begin
            b = a ^ {$urandom_range(0, 1) == 1, 28'd0, 3'($urandom_range(0, 7))};
         end else begin
            b = rand_fp(int'(a[30:23]));
         end
         ctrl = 4'($urandom_range(0, 15));
         send(a, b, ctrl, model(a, b, ctrl));
         if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 2)));
      end
      idle(5);

      // reset with two operations in flight
      send(32'h3F800000, 32'h40000000, 4'b0000, model(32'h3F800000, 32'h40000000, 4'b0000));
      send(32'h40400000, 32'h40800000, 4'b0000, model(32'h40400000, 32'h40800000, 4'b0000));
      valid = 1'b0;
      #2 rst = 1'b1;
      exp_q.delete();
      due_q.delete();
      last_exp = '0;
      #1;
      check("mid_reset_outputs", {result, flags, done, ready}, 39'd0);
      @(posedge clk);
      #1;
      check("held_reset_outputs", {result, flags, done, ready}, 39'd0);
      rst = 1'b0;
      idle(6);
      directed("post_reset", 32'h3F800000, 32'h3F800000, 4'b0100, 32'h00000000, 5'b00001);
      idle(5);
      check("queue_drained", 39'(exp_q.size()), 39'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
